board_state_tracker: RTL and testbench

- Parametrised N×N macro-board state store with a sequential win/draw evaluator; generalises the fixed 3×3 board-state RAM.
- Cells hold 2-bit outcomes (00 open, 01 P1, 10 P2, 11 tied cell). After each accepted write, an FSM scans one line per cycle and publishes the overall game result with a valid flag.
- Sits between the macro-cell resolvers, which write outcomes, and the top-level game controller and display, which read the result and cells.

---
 rtl/board_pkg.sv | 24 ++
 rtl/board_line_check.sv | 21 ++
 rtl/board_state_tracker.sv | 144 ++++++++++++++
 tb/tb_board_state_tracker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared encodings, FSM states and line-index helpers for the macro-board state tracker.
package board_pkg;

  localparam logic [1:0] ST_OPEN = 2'b00;
  localparam logic [1:0] ST_P1   = 2'b01;
  localparam logic [1:0] ST_P2   = 2'b10;
  localparam logic [1:0] ST_TIE  = 2'b11;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} fsm_state_e;

  // Line numbering: rows 0..n-1, columns n..2n-1, main diagonal 2n, anti-diagonal 2n+1.
  function automatic int unsigned num_lines(input int unsigned n);
    return 2 * n + 2;
  endfunction

  function automatic int unsigned col_line_base(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned diag_line(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/board_line_check.sv
// Flags whether every cell of one selected line belongs to P1 or to P2.
module board_line_check
  import board_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [2*N-1:0] cells,
  output logic           p1_all,
  output logic           p2_all
);

  always_comb begin
    p1_all = 1'b1;
    p2_all = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (cells[2*i +: 2] != ST_P1) p1_all = 1'b0;
      if (cells[2*i +: 2] != ST_P2) p2_all = 1'b0;
    end
  end

endmodule

// File: rtl/board_state_tracker.sv
// N x N macro-board cell store with a fixed-latency sequential win/draw evaluator.
module board_state_tracker
  import board_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  output logic          wr_err,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_data,
  output logic [1:0]    state_final,
  output logic          state_valid,
  output logic          busy
);

  localparam int unsigned CELLS = N * N;
  localparam int unsigned L     = num_lines(N);
  localparam int unsigned LW    = $clog2(L);
  localparam int unsigned CW    = $clog2(CELLS + 1);
  localparam int unsigned COLS  = col_line_base(N);
  localparam int unsigned DIAG  = diag_line(N);

  logic [CELLS-1:0][1:0] cells;
  fsm_state_e            state;
  logic [LW-1:0]         line_idx;
  logic [CW-1:0]         occ;
  logic                  win1;
  logic                  win2;
  logic [2*N-1:0]        line_cells;
  logic                  p1_all;
  logic                  p2_all;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_take;
  logic                  wr_bad;
  int unsigned           li;
  int unsigned           ci;

  assign wr_in_range = {1'b0, wr_addr} < (AW+1)'(CELLS);
  assign rd_in_range = {1'b0, rd_addr} < (AW+1)'(CELLS);
  assign wr_take     = wr_valid && wr_ready && !clr;
  assign wr_bad      = (wr_data == ST_OPEN) || !wr_in_range ||
                       (cells[wr_addr] != ST_OPEN) || (state_final != ST_OPEN);

  // Gather the cells of the line currently being scanned.
  always_comb begin
    line_cells = '0;
    li = 32'(line_idx);
    ci = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (li < COLS)       ci = li * N + i;
      else if (li < DIAG)  ci = i * N + (li - COLS);
      else if (li == DIAG) ci = i * N + i;
      else                 ci = i * N + (N - 1 - i);
      line_cells[2*i +: 2] = cells[AW'(ci)];
    end
  end

  board_line_check #(.N(N)) u_line_check (
    .cells  (line_cells),
    .p1_all (p1_all),
    .p2_all (p2_all)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells       <= '0;
      state       <= IDLE;
      line_idx    <= '0;
      occ         <= '0;
      win1        <= 1'b0;
      win2        <= 1'b0;
      state_final <= ST_OPEN;
      state_valid <= 1'b1;
      busy        <= 1'b0;
      wr_ready    <= 1'b1;
      wr_err      <= 1'b0;
    end else if (clr) begin
      cells       <= '0;
      state       <= IDLE;
      line_idx    <= '0;
      occ         <= '0;
      win1        <= 1'b0;
      win2        <= 1'b0;
      state_final <= ST_OPEN;
      state_valid <= 1'b1;
      busy        <= 1'b0;
      wr_ready    <= 1'b1;
      wr_err      <= 1'b0;
    end else begin
      wr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_take) begin
            if (wr_bad) begin
              wr_err <= 1'b1;
            end else begin
              cells[wr_addr] <= wr_data;
              occ            <= occ + CW'(1);
              line_idx       <= '0;
              state_valid    <= 1'b0;
              busy           <= 1'b1;
              wr_ready       <= 1'b0;
              state          <= SCAN;
            end
          end
        end
        SCAN: begin
          win1 <= win1 | p1_all;
          win2 <= win2 | p2_all;
          if (line_idx == LW'(L - 1)) state <= DONE;
          else                        line_idx <= line_idx + LW'(1);
        end
        DONE: begin
          if (win1 || win2)             state_final <= {win2, win1};
          else if (occ == CW'(CELLS))   state_final <= ST_TIE;
          else                          state_final <= ST_OPEN;
          state_valid <= 1'b1;
          win1        <= 1'b0;
          win2        <= 1'b0;
          busy        <= 1'b0;
          wr_ready    <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read port ignores clr; a same-edge write is seen on the following read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           rd_data <= ST_OPEN;
    else if (rd_in_range) rd_data <= cells[rd_addr];
    else                  rd_data <= ST_OPEN;
  end

endmodule

// File: tb/tb_board_state_tracker.sv
// Directed table-driven bench for board_state_tracker with N=3 and N=4 instances on shared inputs.
module tb_board_state_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic [3:0] rd_addr = '0;

  logic       r3, e3, v3, b3, r4, e4, v4, b4;
  logic [1:0] rd3, f3, rd4, f4;

  bit         sel4 = 1'b0;
  logic       o_ready, o_err, o_valid, o_busy;
  logic [1:0] o_rd, o_final;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  board_state_tracker #(.N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_valid(wr_valid), .wr_ready(r3),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(e3), .rd_addr(rd_addr),
    .rd_data(rd3), .state_final(f3), .state_valid(v3), .busy(b3)
  );

  board_state_tracker #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_valid(wr_valid), .wr_ready(r4),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(e4), .rd_addr(rd_addr),
    .rd_data(rd4), .state_final(f4), .state_valid(v4), .busy(b4)
  );

  assign o_ready = sel4 ? r4  : r3;
  assign o_err   = sel4 ? e4  : e3;
  assign o_valid = sel4 ? v4  : v3;
  assign o_busy  = sel4 ? b4  : b3;
  assign o_rd    = sel4 ? rd4 : rd3;
  assign o_final = sel4 ? f4  : f3;

  typedef struct {
    bit         clr_first;
    bit         n4;
    logic [3:0] addr;
    logic [1:0] data;
    logic       exp_err;
    logic [1:0] exp_final;
    logic [3:0] rd_a;
    logic [1:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit c, input bit n4, input logic [3:0] a, input logic [1:0] d,
                     input logic e, input logic [1:0] f, input logic [3:0] ra,
                     input logic [1:0] rv);
    vec_t v;
    v.clr_first = c; v.n4 = n4; v.addr = a; v.data = d;
    v.exp_err = e; v.exp_final = f; v.rd_a = ra; v.exp_rd = rv;
    vecs.push_back(v);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [1:0] d, output logic err);
    int n = 0;
    while (o_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (o_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: wr_ready stayed %b, required 1", o_ready);
    end
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
    err = o_err;
  endtask

  // Called just after the accepting edge: valid must stay low through edge L, result on edge L+1.
  task automatic wait_result(input string name, input logic [1:0] exp_final);
    int  lines = sel4 ? 10 : 8;
    bit  low_ok = 1'b1;
    for (int i = 0; i <= lines; i++) begin
      if (o_valid !== 1'b0) low_ok = 1'b0;
      @(negedge clk);
    end
    check({name, "_valid_low"}, 4'(low_ok), 4'h1);
    check({name, "_valid"}, 4'(o_valid), 4'h1);
    check({name, "_final"}, 4'(o_final), 4'(exp_final));
  endtask

  initial begin
    logic err;

    // N=3 row win, then rejects
    add(1, 0, 4'd0, 2'b01, 0, 2'b00, 4'd0, 2'b01);
    add(0, 0, 4'd1, 2'b01, 0, 2'b00, 4'd1, 2'b01);
    add(0, 0, 4'd2, 2'b01, 0, 2'b01, 4'd2, 2'b01);
    add(0, 0, 4'd5, 2'b01, 1, 2'b01, 4'd5, 2'b00);
    add(1, 0, 4'd0, 2'b00, 1, 2'b00, 4'd0, 2'b00);
    add(0, 0, 4'd9, 2'b01, 1, 2'b00, 4'd9, 2'b00);
    add(0, 0, 4'd0, 2'b10, 0, 2'b00, 4'd0, 2'b10);
    add(0, 0, 4'd0, 2'b01, 1, 2'b00, 4'd0, 2'b10);
    // anti-diagonal P2
    add(1, 0, 4'd2, 2'b10, 0, 2'b00, 4'd2, 2'b10);
    add(0, 0, 4'd4, 2'b10, 0, 2'b00, 4'd4, 2'b10);
    add(0, 0, 4'd6, 2'b10, 0, 2'b10, 4'd6, 2'b10);
    // column 1 P2
    add(1, 0, 4'd1, 2'b10, 0, 2'b00, 4'd1, 2'b10);
    add(0, 0, 4'd4, 2'b10, 0, 2'b00, 4'd4, 2'b10);
    add(0, 0, 4'd7, 2'b10, 0, 2'b10, 4'd7, 2'b10);
    // main diagonal P1
    add(1, 0, 4'd0, 2'b01, 0, 2'b00, 4'd0, 2'b01);
    add(0, 0, 4'd4, 2'b01, 0, 2'b00, 4'd4, 2'b01);
    add(0, 0, 4'd8, 2'b01, 0, 2'b01, 4'd8, 2'b01);
    // full board, no line, with a tied cell -> draw
    add(1, 0, 4'd0, 2'b01, 0, 2'b00, 4'd0, 2'b01);
    add(0, 0, 4'd1, 2'b10, 0, 2'b00, 4'd1, 2'b10);
    add(0, 0, 4'd2, 2'b01, 0, 2'b00, 4'd2, 2'b01);
    add(0, 0, 4'd3, 2'b01, 0, 2'b00, 4'd3, 2'b01);
    add(0, 0, 4'd4, 2'b10, 0, 2'b00, 4'd4, 2'b10);
    add(0, 0, 4'd5, 2'b10, 0, 2'b00, 4'd5, 2'b10);
    add(0, 0, 4'd6, 2'b10, 0, 2'b00, 4'd6, 2'b10);
    add(0, 0, 4'd7, 2'b01, 0, 2'b00, 4'd7, 2'b01);
    add(0, 0, 4'd8, 2'b11, 0, 2'b11, 4'd8, 2'b11);
    // N=4 anti-diagonal P2
    add(1, 1, 4'd3,  2'b10, 0, 2'b00, 4'd3,  2'b10);
    add(0, 1, 4'd6,  2'b10, 0, 2'b00, 4'd6,  2'b10);
    add(0, 1, 4'd9,  2'b10, 0, 2'b00, 4'd9,  2'b10);
    add(0, 1, 4'd12, 2'b10, 0, 2'b10, 4'd12, 2'b10);

    // reset values
    repeat (2) @(negedge clk);
    check("rst_final", 4'(o_final), 4'h0);
    check("rst_valid", 4'(o_valid), 4'h1);
    check("rst_ready", 4'(o_ready), 4'h1);
    check("rst_busy",  4'(o_busy),  4'h0);
    check("rst_err",   4'(o_err),   4'h0);
    rst_n = 1'b1;
    rd_addr = 4'd4;
    @(negedge clk);
    check("rst_rd4", 4'(o_rd), 4'h0);

    foreach (vecs[k]) begin
      sel4 = vecs[k].n4;
      if (vecs[k].clr_first) pulse_clr();
      do_write(vecs[k].addr, vecs[k].data, err);
      check($sformatf("v%0d_err", k), 4'(err), 4'(vecs[k].exp_err));
      if (vecs[k].exp_err) begin
        check($sformatf("v%0d_valid", k), 4'(o_valid), 4'h1);
        check($sformatf("v%0d_final", k), 4'(o_final), 4'(vecs[k].exp_final));
        @(negedge clk);
        check($sformatf("v%0d_err_pulse", k), 4'(o_err), 4'h0);
        check($sformatf("v%0d_noscan", k), 4'(o_busy), 4'h0);
      end else begin
        wait_result($sformatf("v%0d", k), vecs[k].exp_final);
      end
      rd_addr = vecs[k].rd_a;
      @(negedge clk);
      check($sformatf("v%0d_rd", k), 4'(o_rd), 4'(vecs[k].exp_rd));
    end

    // same-cycle read of the written cell returns the old value
    sel4 = 1'b0;
    pulse_clr();
    rd_addr = 4'd3;
    do_write(4'd3, 2'b01, err);
    check("rw_old", 4'(o_rd), 4'h0);
    @(negedge clk);
    check("rw_new", 4'(o_rd), 4'h1);
    repeat (12) @(negedge clk);
    check("rw_final", 4'(o_final), 4'h0);

    // clr mid-scan with a simultaneous write
    pulse_clr();
    do_write(4'd0, 2'b01, err);
    repeat (3) @(negedge clk);
    check("ms_busy", 4'(o_busy), 4'h1);
    check("ms_ready", 4'(o_ready), 4'h0);
    clr = 1'b1; wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 2'b01;
    @(negedge clk);
    clr = 1'b0; wr_valid = 1'b0;
    check("clr_valid", 4'(o_valid), 4'h1);
    check("clr_final", 4'(o_final), 4'h0);
    check("clr_err",   4'(o_err),   4'h0);
    check("clr_ready", 4'(o_ready), 4'h1);
    check("clr_busy",  4'(o_busy),  4'h0);
    rd_addr = 4'd0;
    @(negedge clk);
    check("clr_rd0", 4'(o_rd), 4'h0);
    rd_addr = 4'd1;
    @(negedge clk);
    check("clr_rd1", 4'(o_rd), 4'h0);
    repeat (12) @(negedge clk);
    check("clr_late_valid", 4'(o_valid), 4'h1);

    // asynchronous reset mid-scan
    do_write(4'd4, 2'b01, err);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy",  4'(o_busy),  4'h0);
    check("mrst_valid", 4'(o_valid), 4'h1);
    check("mrst_ready", 4'(o_ready), 4'h1);
    check("mrst_final", 4'(o_final), 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_addr = 4'd4;
    @(negedge clk);
    check("mrst_rd4", 4'(o_rd), 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
